tm_train_sequencer: RTL and testbench
=====================================

# tm_train_sequencer

Training-run sequencer for the Tsetlin machine, sitting directly downstream of the system clock source and upstream of the Tsetlin core. It consumes `clk`, derives a prescaled step tick, and steps the core through LOAD → EVAL → FEEDBACK phases for every sample of every epoch. Each phase is issued to the core with a valid/ready handshake. It reports progress indices and a completion pulse.

## Interface
- `DIV`, 4: clk cycles per prescaler tick; legal range ≥1.
- `N_SAMPLES`, 4: samples per epoch; ≥1.
- `N_EPOCHS`, 8: epochs per run; ≥1.
- `SW`, `$clog2(N_SAMPLES)` with a minimum of 1: sample index width (derived).
- `EW`, `$clog2(N_EPOCHS)` with a minimum of 1: epoch index width (derived).

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  single-cycle request to begin a run; honoured only in IDLE.
- `abort`  in  1  synchronous; returns to IDLE from any state.
- `core_ready`  in  1  core accepts the current phase.
- `phase`  out  2  0=IDLE/none, 1=LOAD, 2=EVAL, 3=FEEDBACK.
- `phase_valid`  out  1  phase request; held until handshake.
- `sample_idx`  out  SW  current sample.
- `epoch_idx`  out  EW  current epoch.
- `tick`  out  1  prescaler pulse.
- `busy`  out  1  high from run start through the DONE state.
- `done`  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, LOAD, EVAL, FEEDBACK, DONE.
- IDLE → LOAD when `start`=1 and `abort`=0. Entering LOAD clears `sample_idx`, `epoch_idx` and the prescaler.
- Prescaler:
  - Counts 0..DIV-1 while in a phase state with `phase_valid`=0.
  - `tick`=1 on the cycle the count equals DIV-1.
  - Count resets to 0 on handshake and on entry from IDLE.
  - With DIV=1, `tick` is high on every counting cycle.
- In LOAD, EVAL and FEEDBACK:
  - `phase` shows the state encoding.
  - `phase_valid` is registered high the cycle after `tick` and held.
  - Handshake occurs on a cycle with `phase_valid`=1 and `core_ready`=1. On the following cycle `phase_valid`=0 and the state advances.
  - `core_ready` while `phase_valid`=0 has no effect.
- Transitions on handshake:
  - LOAD → EVAL.
  - EVAL → FEEDBACK.
  - FEEDBACK → LOAD, after advancing the indices.
  - FEEDBACK → DONE on the last sample of the last epoch.
- Index advance:
  - `sample_idx`=N_SAMPLES-1 wraps to 0 and increments `epoch_idx`; otherwise `sample_idx`+1.
  - On the last sample of the last epoch the indices do not advance; they hold their final values until the next start.
- DONE lasts one cycle with `done`=1, `busy`=1, `phase`=0, then → IDLE.
- Abort:
  - Any state → IDLE on the next cycle: `phase_valid`=0, `busy`=0, `phase`=0, `done` not pulsed.
  - Indices hold their values.
  - `abort` and `start` together in IDLE: abort wins and the FSM stays in IDLE.
- `start` is ignored while `busy`.

## Timing
- Reset values (asynchronous, while `rst_n`=0): state IDLE; `phase`=0, `phase_valid`=0, `sample_idx`=0, `epoch_idx`=0, `tick`=0, `busy`=0, `done`=0; prescaler=0.
- All outputs are registered; no combinational path from any input to any output.
- With `start` accepted in cycle 0:
  - LOAD is entered and `busy`=1 in cycle 1.
  - First `tick` in cycle DIV.
  - First `phase_valid` in cycle DIV+1.
- With `core_ready` held at 1, each phase takes DIV+1 cycles (handshake to handshake).
- A full run with `core_ready`=1 has 3·N_SAMPLES·N_EPOCHS handshakes:
  - last handshake at cycle DIV+1+(3·N_SAMPLES·N_EPOCHS−1)·(DIV+1);
  - `done` the next cycle;
  - IDLE the cycle after that.
- Deasserting `rst_n` mid-run returns all outputs to their reset values immediately, independent of `clk`.

## Test plan
- Reset with DIV=4, N_SAMPLES=2, N_EPOCHS=2: pulse `rst_n` low → all outputs 0 with no clk edge; FSM in IDLE.
- Nominal run, same parameters, `core_ready`=1, `start` in cycle 0:
  - `phase_valid` high in cycles 5, 10, …, 60 with `phase` sequence 1,2,3 repeating.
  - `sample_idx`/`epoch_idx` progress 0/0, 1/0, 0/1, 1/1.
  - `done`=1 only in cycle 61; `busy` low from cycle 62.
- Backpressure: hold `core_ready`=0 for 7 cycles after the first `phase_valid` → `phase_valid` stays high and `phase`=1 for those 7 cycles, no `tick`; EVAL follows the cycle after `core_ready` rises.
- Abort during EVAL of sample 1, epoch 0 → next cycle IDLE, `busy`=0, `phase_valid`=0, no `done`, indices stay 1/0. A following `start` restarts at 0/0.
- Simultaneous `start`+`abort` in IDLE → FSM stays in IDLE. `start` pulsed mid-run → no effect on the sequence or indices.
- DIV=1, N_SAMPLES=1, N_EPOCHS=1, `core_ready`=1 → `phase_valid` high in cycles 2, 4, 6; `done` in cycle 7; `tick` high in cycles 1, 3, 5.

Source files
------------

// File: rtl/tm_train_sequencer.sv
// rtl/tm_train_sequencer.sv - Tsetlin machine training-run sequencer (LOAD/EVAL/FEEDBACK per sample, per epoch)
module tm_train_sequencer #(
    parameter int DIV       = 4,
    parameter int N_SAMPLES = 4,
    parameter int N_EPOCHS  = 8,
    parameter int SW        = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1,
    parameter int EW        = (N_EPOCHS > 1) ? $clog2(N_EPOCHS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic          core_ready,
    output logic [1:0]    phase,
    output logic          phase_valid,
    output logic [SW-1:0] sample_idx,
    output logic [EW-1:0] epoch_idx,
    output logic          tick,
    output logic          busy,
    output logic          done
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [SW-1:0] S_LAST   = SW'(N_SAMPLES - 1);
    localparam logic [EW-1:0] E_LAST   = EW'(N_EPOCHS - 1);

    // Phase states are encoded so their low two bits equal the phase output code.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_EVAL     = 3'd2,
        ST_FEEDBACK = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            pv_n;
    logic [SW-1:0]   sidx_n;
    logic [EW-1:0]   eidx_n;
    logic            in_phase_n;
    logic            counting_n;
    logic [2:0]      state_bits_n;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pv_n    = phase_valid;
        sidx_n  = sample_idx;
        eidx_n  = epoch_idx;
        if (abort) begin
            state_n = ST_IDLE;
            pv_n    = 1'b0;
            cnt_n   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state_n = ST_LOAD;
                        cnt_n   = '0;
                        pv_n    = 1'b0;
                        sidx_n  = '0;
                        eidx_n  = '0;
                    end
                end
                ST_LOAD, ST_EVAL, ST_FEEDBACK: begin
                    if (phase_valid) begin
                        if (core_ready) begin
                            pv_n  = 1'b0;
                            cnt_n = '0;
                            case (state)
                                ST_LOAD: state_n = ST_EVAL;
                                ST_EVAL: state_n = ST_FEEDBACK;
                                default: begin
                                    if (sample_idx == S_LAST && epoch_idx == E_LAST) begin
                                        state_n = ST_DONE;
                                    end else begin
                                        state_n = ST_LOAD;
                                        if (sample_idx == S_LAST) begin
                                            sidx_n = '0;
                                            eidx_n = epoch_idx + EW'(1);
                                        end else begin
                                            sidx_n = sample_idx + SW'(1);
                                        end
                                    end
                                end
                            endcase
                        end
                    end else begin
                        // The tick cycle is the one where cnt hits its last value.
                        pv_n  = (cnt == CNT_LAST);
                        cnt_n = (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
                    end
                end
                ST_DONE: state_n = ST_IDLE;
                default: state_n = ST_IDLE;
            endcase
        end
        state_bits_n = state_n;
        in_phase_n   = (state_n == ST_LOAD) || (state_n == ST_EVAL) || (state_n == ST_FEEDBACK);
        counting_n   = in_phase_n && !pv_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            phase       <= 2'd0;
            phase_valid <= 1'b0;
            sample_idx  <= '0;
            epoch_idx   <= '0;
            tick        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            phase       <= in_phase_n ? state_bits_n[1:0] : 2'd0;
            phase_valid <= pv_n;
            sample_idx  <= sidx_n;
            epoch_idx   <= eidx_n;
            tick        <= counting_n && (cnt_n == CNT_LAST);
            busy        <= (state_n != ST_IDLE);
            done        <= (state_n == ST_DONE);
        end
    end

endmodule

// File: tb/tb_tm_train_sequencer.sv
// tb/tb_tm_train_sequencer.sv - scoreboard bench for tm_train_sequencer
module tb_tm_train_sequencer;

    localparam int DIV = 4;
    localparam int NS  = 2;
    localparam int NE  = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, abort, core_ready;
    logic [1:0] phase;
    logic       phase_valid, tick, busy, done;
    logic [0:0] sample_idx, epoch_idx;

    logic       start_b;
    logic [1:0] phase_b;
    logic       phase_valid_b, tick_b, busy_b, done_b;
    logic [0:0] sample_idx_b, epoch_idx_b;

    tm_train_sequencer #(.DIV(DIV), .N_SAMPLES(NS), .N_EPOCHS(NE)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .core_ready(core_ready),
        .phase(phase), .phase_valid(phase_valid), .sample_idx(sample_idx),
        .epoch_idx(epoch_idx), .tick(tick), .busy(busy), .done(done)
    );

    tm_train_sequencer #(.DIV(1), .N_SAMPLES(1), .N_EPOCHS(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(1'b0), .core_ready(1'b1),
        .phase(phase_b), .phase_valid(phase_valid_b), .sample_idx(sample_idx_b),
        .epoch_idx(epoch_idx_b), .tick(tick_b), .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int ph;
        int s;
        int e;
        int at;
    } item_t;

    item_t sb[$];
    int    done_due = -1;

    // Expected handshake stream of one full run; at = -1 means timing is not checked.
    task automatic model_run(input int c0, input bit timed);
        int k;
        item_t it;
        k = 0;
        for (int e = 0; e < NE; e++)
            for (int s = 0; s < NS; s++)
                for (int p = 1; p <= 3; p++) begin
                    it.ph = p;
                    it.s  = s;
                    it.e  = e;
                    it.at = timed ? c0 + (DIV + 1) * (k + 1) : -1;
                    sb.push_back(it);
                    k++;
                end
    endtask

    always @(negedge clk) begin
        item_t it;
        if (rst_n) begin
            if (phase_valid && core_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL hs_unexpected: got handshake phase %0d expected none", phase);
                end else begin
                    it = sb.pop_front();
                    check("hs_phase", phase, it.ph);
                    check("hs_sample", sample_idx, it.s);
                    check("hs_epoch", epoch_idx, it.e);
                    if (it.at >= 0) check("hs_cycle", cyc, it.at);
                    if (sb.size() == 0) done_due = cyc + 1;
                end
            end
            if (done) begin
                check("done_cycle", cyc, done_due);
                done_due = -1;
            end
            check("no_tick_while_valid", tick && phase_valid, 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget, output int at);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("run_finished", busy, 0);
        check("no_pending_handshakes", sb.size(), 0);
        at = cyc;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_phase"}, phase, 0);
        check({tag, "_valid"}, phase_valid, 0);
        check({tag, "_sidx"}, sample_idx, 0);
        check({tag, "_eidx"}, epoch_idx, 0);
        check({tag, "_tick"}, tick, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    initial begin
        int c0, at, n;
        logic [15:0] pv_mask, tick_mask, done_mask;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; core_ready = 1'b1; start_b = 1'b0;
        #1;
        check_zero("reset");
        check("reset_b_busy", busy_b, 0);
        check("reset_b_valid", phase_valid_b, 0);
        #10 rst_n = 1'b1;
        step();

        // Nominal timed run
        c0 = cyc;
        model_run(c0, 1'b1);
        start = 1'b1;
        step();
        start = 1'b0;
        @(negedge clk);
        check("load_busy", busy, 1);
        check("load_phase", phase, 1);
        check("load_valid", phase_valid, 0);
        wait_idle(200, at);
        check("idle_cycle", at, c0 + (3 * NS * NE) * (DIV + 1) + 2);
        check("final_sidx", sample_idx, NS - 1);
        check("final_eidx", epoch_idx, NE - 1);

        // Backpressure on the first LOAD
        step();
        core_ready = 1'b0;
        model_run(cyc, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        @(negedge clk);
        while (!phase_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 7; i++) begin
            check("bp_valid", phase_valid, 1);
            check("bp_phase", phase, 1);
            check("bp_tick", tick, 0);
            step();
        end
        core_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_eval_phase", phase, 2);
        check("bp_eval_valid", phase_valid, 0);
        wait_idle(200, at);

        // Abort during EVAL of sample 1, epoch 0
        step();
        model_run(cyc, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (sb.size() > 3 * NS * NE - 4 && n < 100) begin
            step();
            n++;
        end
        check("abort_reached_eval", phase, 2);
        abort = 1'b1;
        sb.delete();
        done_due = -1;
        step();
        abort = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_valid", phase_valid, 0);
        check("abort_phase", phase, 0);
        check("abort_done", done, 0);
        check("abort_sidx", sample_idx, 1);
        check("abort_eidx", epoch_idx, 0);
        for (int i = 0; i < 8; i++) step();
        model_run(cyc, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_idle(200, at);

        // start and abort together in IDLE
        step();
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("start_abort_busy", busy, 0);
            check("start_abort_phase", phase, 0);
        end

        // Randomized backpressure with stray start pulses
        for (int r = 0; r < 3; r++) begin
            step();
            model_run(cyc, 1'b0);
            start = 1'b1;
            step();
            start = 1'b0;
            n = 0;
            while (busy && n < 2000) begin
                core_ready = 1'($urandom_range(0, 1));
                start = (!done && ($urandom_range(0, 7) == 0)) ? 1'b1 : 1'b0;
                step();
                n++;
            end
            start = 1'b0;
            core_ready = 1'b1;
            wait_idle(200, at);
        end

        // DIV=1, one sample, one epoch
        step();
        c0 = cyc;
        pv_mask = '0;
        tick_mask = '0;
        done_mask = '0;
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        for (int k = 1; k < 12; k++) begin
            @(negedge clk);
            pv_mask[k]   = phase_valid_b;
            tick_mask[k] = tick_b;
            done_mask[k] = done_b;
        end
        check("div1_valid_cycles", pv_mask, 16'b0000_0000_0101_0100);
        check("div1_tick_cycles", tick_mask, 16'b0000_0000_0010_1010);
        check("div1_done_cycles", done_mask, 16'b0000_0000_1000_0000);
        check("div1_busy_end", busy_b, 0);

        // Asynchronous reset mid-run
        step();
        model_run(cyc, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) step();
        #2;
        rst_n = 1'b0;
        sb.delete();
        done_due = -1;
        #1;
        check_zero("async_reset");
        step();
        rst_n = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
